// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake on both sides.
// Single-cycle ops (add/sub/logic/shift) finish on the accept edge.
// The unsigned multiply is an iterative shift-add over WIDTH cycles.
// A stored carry register supports multi-word add/sub chains.
module seq_alu #(
  parameter int         WIDTH       = 16,
  parameter logic [0:0] RESET_CARRY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inC,
  input  logic             cSel,
  input  logic [2:0]       opc,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outW,
  output logic             zer,
  output logic             neg,
  output logic             cout,
  output logic             ovf,
  output logic             outValid,
  input  logic             outReady
);

  // Step counter must hold values 0..WIDTH-1.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Result and flag registers, all loaded on the same edge.
  logic [WIDTH-1:0] r_outW;
  logic             r_zer;
  logic             r_neg;
  logic             r_cout;
  logic             r_ovf;

  // Stored carry for chained multi-word add/sub.
  logic             r_creg;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  // Handshake and decode.
  logic w_accept;
  logic w_is_mul;
  logic w_is_addsub;
  logic w_ce;
  logic w_mul_last;

  // Single-cycle ALU.
  logic [WIDTH-1:0] w_b_op;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_alu_w;
  logic             w_alu_cout;
  logic             w_alu_ovf;

  // Multiplier step.
  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0]   w_mul_w;
  logic               w_mul_cout;

  // Result mux into the output registers.
  logic             w_load;
  logic [WIDTH-1:0] w_res_w;
  logic             w_res_cout;
  logic             w_res_ovf;

  assign w_accept    = inValid && (r_state == S_IDLE);
  assign w_is_mul    = (opc == OP_MUL);
  assign w_is_addsub = (opc == OP_ADD) || (opc == OP_SUB);
  assign w_ce        = cSel ? r_creg : inC;
  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == LAST_STEP);

  // Subtract is A + ~B + ~Ce so one adder serves both; cout then means "no borrow".
  assign w_b_op    = (opc == OP_SUB) ? ~inB : inB;
  assign w_cin     = (opc == OP_SUB) ? ~w_ce : w_ce;
  assign w_sum     = {1'b0, inA} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_cin};
  // Overflow: both adder operands share a sign that the result does not.
  assign w_add_ovf = (inA[WIDTH-1] == w_b_op[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != inA[WIDTH-1]);

  // Partial product for the current multiplier bit.
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_w    = w_acc_step[WIDTH-1:0];
  assign w_mul_cout = |w_acc_step[2*WIDTH-1:WIDTH];

  // Accept and multiply completion are mutually exclusive (IDLE vs MUL state).
  assign w_load     = (w_accept && !w_is_mul) || w_mul_last;
  assign w_res_w    = w_mul_last ? w_mul_w    : w_alu_w;
  assign w_res_cout = w_mul_last ? w_mul_cout : w_alu_cout;
  assign w_res_ovf  = w_mul_last ? 1'b0       : w_alu_ovf;

  // Single-cycle opcode decode; MUL falls through to zeros and is never loaded here.
  always_comb begin
    w_alu_w    = '0;
    w_alu_cout = 1'b0;
    w_alu_ovf  = 1'b0;
    case (opc)
      OP_ADD, OP_SUB: begin
        w_alu_w    = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
        w_alu_ovf  = w_add_ovf;
      end
      OP_AND: w_alu_w = inA & inB;
      OP_OR:  w_alu_w = inA | inB;
      OP_XOR: w_alu_w = inA ^ inB;
      OP_NOT: w_alu_w = ~inA;
      OP_SHR: begin
        w_alu_w    = {w_ce, inA[WIDTH-1:1]};
        w_alu_cout = inA[0];
      end
      default: begin
        w_alu_w    = '0;
        w_alu_cout = 1'b0;
        w_alu_ovf  = 1'b0;
      end
    endcase
  end

  // Next-state logic: IDLE accepts, MUL runs WIDTH steps, DONE waits for the consumer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (r_cnt == LAST_STEP) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (outReady) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Result and flags load together and then hold until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outW <= '0;
      r_zer  <= 1'b0;
      r_neg  <= 1'b0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_outW <= w_res_w;
      r_zer  <= (w_res_w == '0);
      r_neg  <= w_res_w[WIDTH-1];
      r_cout <= w_res_cout;
      r_ovf  <= w_res_ovf;
    end
  end

  // Stored carry follows cout of ADD/SUB only; every other op leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_creg <= RESET_CARRY;
    end else if (w_accept && w_is_addsub) begin
      r_creg <= w_alu_cout;
    end
  end

  // Multiplier: latch operands on accept, then one shift-add per cycle, LSB of B first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, inA};
      r_mplier <= inB;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_step;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign inReady  = (r_state == S_IDLE);
  assign outValid = (r_state == S_DONE);
  assign outW     = r_outW;
  assign zer      = r_zer;
  assign neg      = r_neg;
  assign cout     = r_cout;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an
// arithmetic reference model that tracks the stored carry.
module tb_seq_alu;
  localparam int W = 16;
  localparam int M = 1 << W;
  localparam int HALF = M / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] inA, inB;
  logic         inC, cSel;
  logic [2:0]   opc;
  logic         inValid, inReady;
  logic [W-1:0] outW;
  logic         zer, neg, cout, ovf, outValid, outReady;

  int n_vec = 0;
  int n_err = 0;
  int m_creg = 0;

  seq_alu #(.WIDTH(W), .RESET_CARRY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .inA(inA), .inB(inB), .inC(inC), .cSel(cSel),
    .opc(opc), .inValid(inValid), .inReady(inReady), .outW(outW), .zer(zer),
    .neg(neg), .cout(cout), .ovf(ovf), .outValid(outValid), .outReady(outReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on unsigned / signed values.
  function automatic void model(input int op, input int a, input int b, input int ce,
                                output int w, output int co, output int ov);
    int s, sa, sb, sr;
    longint p;
    sa = (a >= HALF) ? a - M : a;
    sb = (b >= HALF) ? b - M : b;
    w = 0; co = 0; ov = 0;
    case (op)
      0: begin
        s = a + b + ce; w = s % M; co = s / M;
        sr = sa + sb + ce; ov = (sr >= HALF || sr < -HALF) ? 1 : 0;
      end
      1: begin
        s = a + (M - 1 - b) + (1 - ce); w = s % M; co = s / M;
        sr = sa - sb - ce; ov = (sr >= HALF || sr < -HALF) ? 1 : 0;
      end
      2: w = a & b;
      3: w = a | b;
      4: w = a ^ b;
      5: w = M - 1 - a;
      6: begin w = ce * HALF + a / 2; co = a % 2; end
      default: begin
        p = longint'(a) * longint'(b);
        w = int'(p % M); co = (p >= M) ? 1 : 0;
      end
    endcase
  endfunction

  // One full transaction: accept, wait for result, optional stall, then consume.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic cs, input int stall,
                       output logic [W-1:0] got_w, output logic got_c);
    int ew, ec, eo, ce, lat;
    @(negedge clk);
    check("inReady_idle", {31'b0, inReady}, 32'd1);
    ce = cs ? m_creg : int'(c);
    model(int'(op), int'(a), int'(b), ce, ew, ec, eo);
    if (op == 3'd0 || op == 3'd1) m_creg = ec;
    inA = a; inB = b; inC = c; cSel = cs; opc = op; inValid = 1'b1; outReady = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!outValid && lat < 100) begin
      // Busy: scramble inputs and offer new ops; none may be taken or disturb the result.
      check("inReady_busy", {31'b0, inReady}, 32'd0);
      inA = W'($urandom); inB = W'($urandom); inC = 1'($urandom);
      cSel = 1'($urandom); opc = 3'($urandom); inValid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (op == 3'd7) ? W : 0);
    check("outW", {16'b0, outW}, ew);
    check("zer", {31'b0, zer}, (ew == 0) ? 1 : 0);
    check("neg", {31'b0, neg}, (ew >= HALF) ? 1 : 0);
    check("cout", {31'b0, cout}, ec);
    check("ovf", {31'b0, ovf}, eo);
    got_w = outW;
    got_c = cout;
    for (int i = 0; i < stall; i++) begin
      inValid = 1'($urandom); opc = 3'($urandom); inA = W'($urandom);
      @(negedge clk);
      check("stall_outW", {16'b0, outW}, ew);
      check("stall_outValid", {31'b0, outValid}, 32'd1);
      check("stall_inReady", {31'b0, inReady}, 32'd0);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    check("consumed_outValid", {31'b0, outValid}, 32'd0);
    check("consumed_inReady", {31'b0, inReady}, 32'd1);
    outReady = 1'b0;
    $display("op=%0d a=0x%04h b=0x%04h ce=%0d -> outW=0x%04h cout=%0d lat=%0d",
             op, a, b, ce, got_w, got_c, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] w;
    logic c;
    bit stale;
    rst_n = 1'b0; inA = '0; inB = '0; inC = 1'b0; cSel = 1'b0; opc = '0;
    inValid = 1'b0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outW", {16'b0, outW}, 32'd0);
    check("rst_flags", {28'b0, zer, neg, cout, ovf}, 32'd0);
    check("rst_outValid", {31'b0, outValid}, 32'd0);
    rst_n = 1'b1;
    m_creg = 0;

    // Carry generation and chaining.
    do_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, w, c);
    check("tp_add_w", {16'b0, w}, 32'h0000);
    check("tp_add_c", {31'b0, c}, 32'd1);
    do_op(3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, w, c);
    check("tp_chain_w", {16'b0, w}, 32'h0001);
    check("tp_chain_c", {31'b0, c}, 32'd0);
    do_op(3'd2, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 0, w, c);
    check("tp_and_w", {16'b0, w}, 32'h00F0);
    do_op(3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 0, w, c);
    check("tp_creg0_w", {16'b0, w}, 32'h0000);
    // Logic op between chained adds must not disturb a set carry.
    do_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, w, c);
    do_op(3'd4, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, w, c);
    do_op(3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, w, c);
    check("tp_creg_kept", {16'b0, w}, 32'h0001);

    do_op(3'd1, 16'h8000, 16'h0001, 1'b0, 1'b0, 0, w, c);
    check("tp_sub_w", {16'b0, w}, 32'h7FFF);
    check("tp_sub_c", {31'b0, c}, 32'd1);
    do_op(3'd6, 16'h0003, 16'h0000, 1'b1, 1'b0, 0, w, c);
    check("tp_shr_w", {16'b0, w}, 32'h8001);
    check("tp_shr_c", {31'b0, c}, 32'd1);
    do_op(3'd7, 16'h0123, 16'h0010, 1'b0, 1'b0, 0, w, c);
    check("tp_mul1_w", {16'b0, w}, 32'h1230);
    check("tp_mul1_c", {31'b0, c}, 32'd0);
    do_op(3'd7, 16'h0100, 16'h0100, 1'b0, 1'b0, 0, w, c);
    check("tp_mul2_w", {16'b0, w}, 32'h0000);
    check("tp_mul2_c", {31'b0, c}, 32'd1);
    do_op(3'd4, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 10, w, c);
    check("tp_xor_w", {16'b0, w}, 32'h5555);

    // Reset in the middle of a multiply, with the stored carry set beforehand.
    do_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, w, c);
    @(negedge clk);
    inA = 16'h1234; inB = 16'h5678; opc = 3'd7; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_mul_busy", {31'b0, inReady}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_outW", {16'b0, outW}, 32'd0);
    check("midrst_flags", {28'b0, zer, neg, cout, ovf}, 32'd0);
    check("midrst_outValid", {31'b0, outValid}, 32'd0);
    m_creg = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_inReady", {31'b0, inReady}, 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (outValid) stale = 1'b1;
    end
    check("postrst_no_stale", {31'b0, stale}, 32'd0);
    do_op(3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 0, w, c);
    check("postrst_creg", {16'b0, w}, 32'h0000);

    // Randomized operations with random carry source and stalls.
    for (int k = 0; k < 150; k++) begin
      do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 2), w, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Registered, parametrised successor to the team's 16-bit combinational ALU (inA/inB/inC/opc -> outW/zer/neg).
- Adds a configurable width and a valid/ready handshake on both input and output.
- Adds a stored carry register for chained multi-word add/sub, plus overflow and carry-out flags.
- Adds an iterative multi-cycle unsigned multiply.
- Sits between an operand-issuing controller and a result consumer. Both sides may stall.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- RESET_CARRY, 0, value loaded into the stored carry register on reset.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inA  input  WIDTH  operand A.
- inB  input  WIDTH  operand B.
- inC  input  1  external carry-in.
- cSel  input  1  carry source: 0 = inC, 1 = stored carry register.
- opc  input  3  opcode.
- inValid  input  1  operands/opcode valid.
- inReady  output  1  block can accept.
- outW  output  WIDTH  result.
- zer  output  1  result == 0.
- neg  output  1  result MSB.
- cout  output  1  carry-out / borrow-not / shifted-out bit.
- ovf  output  1  signed overflow (ADD/SUB only, else 0).
- outValid  output  1  result valid.
- outReady  input  1  consumer accepts result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - outW=0, zer=0, neg=0, cout=0, ovf=0, outValid=0.
  - Stored carry register cReg=RESET_CARRY.
  - Any in-flight op is discarded.
  - inReady=1 once rst_n=1.
- Effective carry: Ce = cSel ? cReg : inC, sampled at acceptance.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 000 ADD: W = A+B+Ce; cout = carry out of bit WIDTH-1; ovf = signed overflow.
  - 001 SUB: W = A + ~B + ~Ce (i.e. A-B-Ce); cout = carry out (1 = no borrow); ovf = signed overflow.
  - 010 AND, 011 OR, 100 XOR: cout=0, ovf=0.
  - 101 NOT: W = ~A; cout=0, ovf=0.
  - 110 SHR: W = {Ce, A[WIDTH-1:1]}; cout = A[0]; ovf=0.
  - 111 MUL: W = low WIDTH bits of unsigned A*B; Ce ignored; cout = 1 if the high WIDTH bits are nonzero; ovf=0.
- Flags: zer = (W==0) and neg = W[WIDTH-1], for every op. All flags are registered together with outW.
- cReg is updated with cout only when an ADD or SUB result is registered. Other ops leave cReg unchanged.
- States: IDLE, MUL, DONE.
- inReady = (state==IDLE). A transfer occurs when inValid && inReady at a rising edge.
- IDLE, accept of a non-MUL op: result and flags registered on the same edge; state->DONE. outValid is therefore high in the cycle after acceptance.
- IDLE, accept of MUL: latch A, B; clear the accumulator and bit counter; state->MUL.
- MUL: one shift-add step per cycle, LSB of B first, for exactly WIDTH cycles. On the edge completing step WIDTH, register the result and flags; state->DONE.
  - outValid therefore rises WIDTH cycles later than for a single-cycle op (e.g. 17 edges after acceptance for WIDTH=16 vs 1).
- DONE: outValid=1. outW and all flags are held stable while outReady=0.
- DONE with outReady=1: on that edge, outValid->0 and state->IDLE. Throughput is at most one op per 2 cycles.
- inValid is ignored (no acceptance) in MUL and DONE. Input changes during MUL do not affect the result.
- opc values are decoded only at acceptance.

Test Plan:
- ADD A=0xFFFF, B=0x0001, inC=0, cSel=0 -> outW=0x0000, zer=1, neg=0, cout=1, ovf=0. outValid high in the cycle after acceptance; cReg=1.
- Carry chaining: immediately after the above, ADD A=0x0000, B=0x0000, cSel=1, inC=0 -> outW=0x0001, cout=0. Then AND 0xF0F0&0x0FF0 -> 0x00F0 and cReg remains 0.
- SUB A=0x8000, B=0x0001, Ce=0 -> outW=0x7FFF, ovf=1, neg=0, cout=1.
- SHR A=0x0003, inC=1 -> outW=0x8001, cout=1, neg=1.
- MUL A=0x0123, B=0x0010 -> outW=0x1230, cout=0, inReady=0 throughout, outValid rises 16 cycles later than a single-cycle op.
- MUL A=0x0100, B=0x0100 -> outW=0x0000, zer=1, cout=1.
- Backpressure: hold outReady=0 for 10 cycles after XOR 0xAAAA^0xFFFF -> outW=0x5555 stable, inReady=0, and a new inValid pulse is not accepted. Raise outReady -> IDLE the next cycle.
- Reset mid-op: assert rst_n=0 at step 8 of a MUL -> all outputs 0 immediately, cReg=RESET_CARRY. After release inReady=1 and no stale outValid.
